// File: rtl/uart_tx_baud.sv
// UART transmitter paced by an external baud square wave: start bit, LSB-first data,
// optional even/odd parity and one or two stop bits, one frame per accepted tx_start.
module uart_tx_baud #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_in,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       txd,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP  = 3'(STOP_BITS - 1);
  localparam logic [7:0] DATA_MASK  = 8'((1 << DATA_BITS) - 1);
  localparam logic       HAS_PARITY = 1'(PARITY_MODE != 0);
  localparam logic       PAR_ODD    = 1'(PARITY_MODE == 2);

  state_t     state_q, state_d;
  logic       baud_q, baud_vld_q;
  logic [7:0] data_q, data_d;
  logic [2:0] cnt_q, cnt_d, cnt_inc;
  logic       txd_q, txd_d;
  logic       done_q, done_d;
  logic       tick, accept, parity_bit;

  // baud_vld_q masks the first cycle after reset so a cleared baud_q cannot fake an edge.
  assign tick       = baud_vld_q & baud_in & ~baud_q;
  // Handshake: tx_start is a one-cycle request taken only in IDLE outside the done
  // cycle; busy is high from the accepting edge until the edge that raises done.
  assign accept     = (state_q == S_IDLE) & tx_start & ~done_q;
  assign cnt_inc    = cnt_q + 3'd1;
  assign parity_bit = (^data_q) ^ PAR_ODD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      baud_q     <= 1'b0;
      baud_vld_q <= 1'b0;
      data_q     <= '0;
      cnt_q      <= '0;
      txd_q      <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_in;
      baud_vld_q <= 1'b1;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      txd_q      <= txd_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_ARMED;
      S_ARMED:  if (tick) state_d = S_START;
      S_START:  if (tick) state_d = S_DATA;
      S_DATA: begin
        if (tick && (cnt_q == LAST_BIT)) state_d = HAS_PARITY ? S_PARITY : S_STOP;
      end
      S_PARITY: if (tick) state_d = S_STOP;
      S_STOP:   if (tick && (cnt_q == LAST_STOP)) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // txd_d is the line level for the state being entered, so txd only moves on a tick.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    txd_d  = txd_q;
    done_d = 1'b0;
    if (accept) data_d = tx_data & DATA_MASK;
    if (tick) begin
      case (state_q)
        S_ARMED: txd_d = 1'b0;
        S_START: begin
          txd_d = data_q[0];
          cnt_d = '0;
        end
        S_DATA: begin
          if (cnt_q == LAST_BIT) begin
            txd_d = HAS_PARITY ? parity_bit : 1'b1;
            cnt_d = '0;
          end else begin
            txd_d = data_q[cnt_inc];
            cnt_d = cnt_inc;
          end
        end
        S_PARITY: begin
          txd_d = 1'b1;
          cnt_d = '0;
        end
        S_STOP: begin
          txd_d = 1'b1;
          if (cnt_q == LAST_STOP) begin
            done_d = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: txd_d = 1'b1;
      endcase
    end
  end

  assign txd     = txd_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_uart_tx_baud.sv
// Bench for uart_tx_baud: four parameter variants, constant frame table, random frames
// against a frame-level model, and hand sequences for the multi-cycle corner cases.
module tb_uart_tx_baud;
  localparam int N_INST      = 4;
  localparam int BAUD_HALF   = 8;
  localparam int TICK_BUDGET = 400;

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic [15:0] bits;
    int         len;
    string      tag;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic baud_in = 1'b0;
  logic [N_INST-1:0] tx_start_w = '0;
  logic [N_INST-1:0][7:0] tx_data_w = '0;
  logic [N_INST-1:0] txd_w, busy_w, done_w;
  logic [N_INST-1:0][2:0] state_w;

  int errors = 0;
  int checks = 0;
  int tick_n = 0;
  logic tb_baud_q = 1'b0;
  logic baud_run = 1'b1;
  int done_cnt [N_INST];
  logic [0:0] exp_q [$];
  vec_t vecs [8];

  uart_tx_baud #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .baud_in(baud_in), .tx_start(tx_start_w[0]), .tx_data(tx_data_w[0]),
    .txd(txd_w[0]), .busy(busy_w[0]), .done(done_w[0]), .state_o(state_w[0]));
  uart_tx_baud #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .baud_in(baud_in), .tx_start(tx_start_w[1]), .tx_data(tx_data_w[1]),
    .txd(txd_w[1]), .busy(busy_w[1]), .done(done_w[1]), .state_o(state_w[1]));
  uart_tx_baud #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .baud_in(baud_in), .tx_start(tx_start_w[2]), .tx_data(tx_data_w[2]),
    .txd(txd_w[2]), .busy(busy_w[2]), .done(done_w[2]), .state_o(state_w[2]));
  uart_tx_baud #(.DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst_n(rst_n), .baud_in(baud_in), .tx_start(tx_start_w[3]), .tx_data(tx_data_w[3]),
    .txd(txd_w[3]), .busy(busy_w[3]), .done(done_w[3]), .state_o(state_w[3]));

  // ---------------- clock / baud ----------------
  initial forever #5 clk = ~clk;

  // Baud changes 2ns after a rising clk edge; tick_n counts the clk edges at which a
  // receiver that registers baud_in once would see a fresh rising edge.
  initial begin
    int phase;
    phase = 0;
    forever begin
      @(posedge clk);
      if (baud_in && !tb_baud_q) tick_n++;
      tb_baud_q = baud_in;
      #2;
      if (baud_run) begin
        phase++;
        if (phase == BAUD_HALF) begin
          phase = 0;
          baud_in = ~baud_in;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N_INST; i++) done_cnt[i] = 0;
    forever begin
      @(posedge clk);
      for (int i = 0; i < N_INST; i++) if (done_w[i] === 1'b1) done_cnt[i]++;
    end
  end

  // ---------------- reference model ----------------
  function automatic int db_of(input int inst);
    return (inst == 3) ? 7 : 8;
  endfunction

  function automatic int par_of(input int inst);
    return (inst == 1) ? 1 : (inst == 2) ? 2 : 0;
  endfunction

  function automatic int sb_of(input int inst);
    return (inst == 3) ? 2 : 1;
  endfunction

  function automatic void build_exp(input int inst, input logic [7:0] data);
    int ones;
    ones = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < db_of(inst); i++) begin
      exp_q.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (par_of(inst) == 1) exp_q.push_back(1'(ones % 2));
    else if (par_of(inst) == 2) exp_q.push_back(1'((ones + 1) % 2));
    for (int s = 0; s < sb_of(inst); s++) exp_q.push_back(1'b1);
  endfunction

  function automatic void load_vec(input logic [15:0] bits, input int len);
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(bits[i]);
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no tick within %0d cycles, expected a tick", name, TICK_BUDGET);
  endtask

  task automatic wait_tick(output bit ok);
    int start;
    start = tick_n;
    ok = 1'b0;
    for (int k = 0; k < TICK_BUDGET; k++) begin
      @(negedge clk);
      if (tick_n != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // txd may only move on a clk edge carrying a tick (reset excepted)
  initial begin
    logic [N_INST-1:0] prev_txd;
    int prev_tick;
    logic prev_rst;
    prev_txd = '1;
    prev_tick = 0;
    prev_rst = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N_INST; i++) begin
        if (rst_n && prev_rst && (txd_w[i] !== prev_txd[i]))
          chk($sformatf("inst%0d txd moved only on tick", i), 32'(tick_n != prev_tick), 32'd1);
      end
      prev_txd = txd_w;
      prev_tick = tick_n;
      prev_rst = rst_n;
    end
  end

  // ---------------- driver ----------------
  task automatic send(input int inst, input logic [7:0] data, input string tag);
    tx_data_w[inst] = data;
    tx_start_w[inst] = 1'b1;
    @(negedge clk);
    tx_start_w[inst] = 1'b0;
    tx_data_w[inst] = 8'($urandom);
    chk({tag, " busy after accept"}, 32'(busy_w[inst]), 32'd1);
  endtask

  // Checks exp_q[first..] on successive ticks, then the done tick; tail adds the cycle after done.
  task automatic check_frame(input int inst, input string tag, input int first, input bit tail);
    bit ok;
    int n;
    int dc0;
    n = exp_q.size();
    dc0 = done_cnt[inst];
    for (int i = first; i < n; i++) begin
      wait_tick(ok);
      if (!ok) begin
        tick_fail({tag, " tick"});
        return;
      end
      chk($sformatf("%s bit%0d txd", tag, i), 32'(txd_w[inst]), 32'(exp_q[i]));
      chk($sformatf("%s bit%0d busy", tag, i), 32'(busy_w[inst]), 32'd1);
      chk($sformatf("%s bit%0d done", tag, i), 32'(done_w[inst]), 32'd0);
    end
    wait_tick(ok);
    if (!ok) begin
      tick_fail({tag, " final tick"});
      return;
    end
    chk({tag, " done at end"}, 32'(done_w[inst]), 32'd1);
    chk({tag, " busy at end"}, 32'(busy_w[inst]), 32'd0);
    chk({tag, " txd idle at end"}, 32'(txd_w[inst]), 32'd1);
    if (tail) begin
      @(negedge clk);
      chk({tag, " done one cycle"}, 32'(done_w[inst]), 32'd0);
      chk({tag, " done count"}, 32'(done_cnt[inst]), 32'(dc0 + 1));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit ok;
    int bad;
    int dc0;
    logic saved_txd;
    logic [2:0] saved_st;

    vecs[0] = '{inst:0, data:8'h55, bits:16'h02AA, len:10, tag:"8N1 0x55"};
    vecs[1] = '{inst:1, data:8'h07, bits:16'h060E, len:11, tag:"8E1 0x07"};
    vecs[2] = '{inst:2, data:8'h07, bits:16'h040E, len:11, tag:"8O1 0x07"};
    vecs[3] = '{inst:3, data:8'h80, bits:16'h0300, len:10, tag:"7N2 0x80"};
    vecs[4] = '{inst:0, data:8'hA5, bits:16'h034A, len:10, tag:"8N1 0xA5"};
    vecs[5] = '{inst:1, data:8'hFF, bits:16'h05FE, len:11, tag:"8E1 0xFF"};
    vecs[6] = '{inst:3, data:8'h7F, bits:16'h03FE, len:10, tag:"7N2 0x7F"};
    vecs[7] = '{inst:2, data:8'h00, bits:16'h0600, len:11, tag:"8O1 0x00"};

    repeat (3) @(negedge clk);
    for (int i = 0; i < N_INST; i++) begin
      chk($sformatf("inst%0d reset txd", i), 32'(txd_w[i]), 32'd1);
      chk($sformatf("inst%0d reset busy", i), 32'(busy_w[i]), 32'd0);
      chk($sformatf("inst%0d reset done", i), 32'(done_w[i]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      load_vec(vecs[v].bits, vecs[v].len);
      send(vecs[v].inst, vecs[v].data, vecs[v].tag);
      check_frame(vecs[v].inst, vecs[v].tag, 0, 1'b1);
    end

    for (int r = 0; r < 6; r++) begin
      for (int inst = 0; inst < N_INST; inst++) begin
        logic [7:0] d;
        string tag;
        d = 8'($urandom);
        tag = $sformatf("rand inst%0d 0x%02h", inst, d);
        repeat ($urandom_range(0, 20)) @(negedge clk);
        build_exp(inst, d);
        send(inst, d, tag);
        check_frame(inst, tag, 0, 1'b1);
      end
    end

    // tx_start with new data in mid-frame must neither corrupt nor queue a frame
    build_exp(0, 8'h00);
    send(0, 8'h00, "midstart");
    for (int i = 0; i < 4; i++) begin
      wait_tick(ok);
      if (!ok) tick_fail("midstart head tick");
      else chk($sformatf("midstart bit%0d txd", i), 32'(txd_w[0]), 32'(exp_q[i]));
    end
    @(negedge clk);
    tx_data_w[0] = 8'hFF;
    tx_start_w[0] = 1'b1;
    @(negedge clk);
    tx_start_w[0] = 1'b0;
    check_frame(0, "midstart", 4, 1'b1);
    dc0 = done_cnt[0];
    bad = 0;
    repeat (6 * BAUD_HALF) begin
      @(negedge clk);
      if (busy_w[0] !== 1'b0 || txd_w[0] !== 1'b1) bad++;
    end
    chk("midstart no second frame", 32'(bad), 32'd0);
    chk("midstart no extra done", 32'(done_cnt[0]), 32'(dc0));

    // reset during data bit 3 aborts the frame at once
    build_exp(0, 8'h00);
    send(0, 8'h00, "abort");
    for (int i = 0; i < 5; i++) begin
      wait_tick(ok);
      if (!ok) tick_fail("abort head tick");
      else chk($sformatf("abort bit%0d txd", i), 32'(txd_w[0]), 32'(exp_q[i]));
    end
    repeat (3) @(negedge clk);
    dc0 = done_cnt[0];
    #1 rst_n = 1'b0;
    #1;
    chk("abort txd high at reset", 32'(txd_w[0]), 32'd1);
    chk("abort busy low at reset", 32'(busy_w[0]), 32'd0);
    chk("abort done low at reset", 32'(done_w[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4 * BAUD_HALF) @(negedge clk);
    chk("abort no done", 32'(done_cnt[0]), 32'(dc0));
    chk("abort idle after reset", 32'(busy_w[0]), 32'd0);
    load_vec(16'h034A, 10);
    send(0, 8'hA5, "after abort 0xA5");
    check_frame(0, "after abort 0xA5", 0, 1'b1);

    // tx_start in the done cycle is ignored, one cycle later it is accepted
    build_exp(0, 8'h3C);
    send(0, 8'h3C, "b2b first");
    check_frame(0, "b2b first", 0, 1'b0);
    tx_data_w[0] = 8'hC3;
    tx_start_w[0] = 1'b1;
    @(negedge clk);
    chk("b2b start in done cycle ignored", 32'(busy_w[0]), 32'd0);
    @(negedge clk);
    tx_start_w[0] = 1'b0;
    chk("b2b start after done accepted", 32'(busy_w[0]), 32'd1);
    build_exp(0, 8'hC3);
    check_frame(0, "b2b second", 0, 1'b1);

    // static baud holds the frame indefinitely
    build_exp(0, 8'h96);
    send(0, 8'h96, "pause");
    for (int i = 0; i < 3; i++) begin
      wait_tick(ok);
      if (!ok) tick_fail("pause head tick");
      else chk($sformatf("pause bit%0d txd", i), 32'(txd_w[0]), 32'(exp_q[i]));
    end
    baud_run = 1'b0;
    saved_txd = txd_w[0];
    saved_st = state_w[0];
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (busy_w[0] !== 1'b1 || txd_w[0] !== saved_txd || state_w[0] !== saved_st) bad++;
    end
    chk("pause holds state", 32'(bad), 32'd0);
    baud_run = 1'b1;
    check_frame(0, "pause", 3, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500_000;
    checks++;
    errors++;
    $display("FAIL watchdog: got no completion by 500us, expected test end");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
